// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam logic PORT_MEM = 1'b0;
  localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/sram_arbiter.sv
// Arbitrates the single SRAM controller port between the MEM stage (port 0)
// and a secondary word master (port 1), with starvation guard and timeout.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_done,
  output logic              m0_freeze,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_done,
  output logic              m1_freeze,
  output logic              ctl_en,
  output logic              ctl_rd,
  output logic [ADDR_W-1:0] ctl_addr,
  output logic [DATA_W-1:0] ctl_wdata,
  input  logic [DATA_W-1:0] ctl_q,
  input  logic              ctl_ready,
  output logic              err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(TIMEOUT + 1);

  arb_state_t    state_q, state_d;
  logic          win_q;
  logic          sel_aux;
  logic          take;
  logic          finish;
  logic          tmo;
  logic [SW-1:0] starve_cnt;
  logic [BW-1:0] busy_cnt;

  // Port 1 wins when it is alone or has waited out STARVE_LIMIT port-0 grants.
  assign sel_aux = m1_req & (~m0_req | (starve_cnt == SW'(STARVE_LIMIT)));

  assign ctl_en    = (state_q == BUSY);
  assign m0_freeze = m0_req & ~m0_done;
  assign m1_freeze = m1_req & ~m1_done;

  // Next-state and per-cycle event decode.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    finish  = 1'b0;
    tmo     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m0_req | m1_req) begin
          take    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Ready takes priority over a timeout reached on the same edge.
        if (ctl_ready) begin
          finish  = 1'b1;
          state_d = RELEASE;
        end else if (busy_cnt == BW'(TIMEOUT - 1)) begin
          finish  = 1'b1;
          tmo     = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Latch the winning request into the controller-facing registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      win_q     <= PORT_MEM;
      ctl_rd    <= 1'b1;
      ctl_addr  <= '0;
      ctl_wdata <= '0;
    end else if (take) begin
      if (sel_aux) begin
        win_q     <= PORT_AUX;
        ctl_rd    <= ~m1_we;
        ctl_addr  <= m1_addr;
        ctl_wdata <= m1_wdata;
      end else begin
        win_q     <= PORT_MEM;
        ctl_rd    <= ~m0_we;
        ctl_addr  <= m0_addr;
        ctl_wdata <= m0_wdata;
      end
    end
  end

  // Count cycles spent in BUSY for the timeout.
  always_ff @(posedge clk) begin
    if (!rst)                 busy_cnt <= '0;
    else if (state_q == BUSY) busy_cnt <= busy_cnt + BW'(1);
    else                      busy_cnt <= '0;
  end

  // Count port-0 grants made while port 1 is waiting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (state_q == IDLE) begin
      if (take && sel_aux) begin
        starve_cnt <= '0;
      end else if (take && m1_req) begin
        if (starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + SW'(1);
      end else if (!m1_req) begin
        starve_cnt <= '0;
      end
    end
  end

  // Completion: done pulse, read data return and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      m0_done  <= 1'b0;
      m1_done  <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      err      <= 1'b0;
    end else begin
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      if (finish) begin
        if (win_q == PORT_AUX) begin
          m1_done <= 1'b1;
          if (ctl_rd) m1_rdata <= tmo ? '0 : ctl_q;
        end else begin
          m0_done <= 1'b1;
          if (ctl_rd) m0_rdata <= tmo ? '0 : ctl_q;
        end
        if (tmo) err <= 1'b1;
      end
    end
  end

endmodule
